intr_ack_ctrl: RTL and testbench
================================

Name: intr_ack_ctrl

Overview:
- Interrupt controller that sits between the peripheral IRQ lines and the MIPS32 core's exception logic.
- Latches source events into a pending register and picks the highest-priority pending source (index 7 highest, index 0 lowest).
- Presents a stable vector to the core with a req/ack handshake.
- On ack, decodes the vector back to a one-hot clear pulse for the peripheral. Tracks the in-service source until the core signals end-of-interrupt.
- Single level only: no nesting.

Parameters:
- N_SRC, 8, number of interrupt sources. Fixed at 8 for this core.
- VEC_W, 3, vector width. Equals log2(N_SRC).
- EDGE_MODE, 1, selects the trigger type. 1 = rising-edge triggered with latched pending bits. 0 = level triggered, where pending equals live irq_src.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- irq_src  in  N_SRC  peripheral interrupt lines, synchronous to clk
- irq_mask  in  N_SRC  per-source enable, 1 = enabled
- ena  in  1  global interrupt enable from CP0 status
- intr_req  out  1  interrupt request to core, registered
- intr_vec  out  VEC_W  vector of the requested source, registered
- intr_ack  in  1  one-cycle core acknowledge
- eoi  in  1  one-cycle core end-of-interrupt
- irq_clr  out  N_SRC  one-hot one-cycle clear pulse to the peripheral
- in_service  out  N_SRC  one-hot in-service register
- busy  out  1  high in REQ or SERVICE

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE.
  - pending, in_service, irq_clr, src_q = 0.
  - intr_req=0, intr_vec=0.
  - If a source is already high at reset release in EDGE_MODE=1, it registers as an edge on the first clock. This is intended.
- Edge detect (EDGE_MODE=1): on each clk edge, a pending bit is set if irq_src[i]=1 and src_q[i]=0; src_q then takes irq_src. Pending bits are cleared only by ack.
- Level mode (EDGE_MODE=0): pending = irq_src combinationally; there is no pending register.
- Eligible set: elig = pending & irq_mask & ~in_service, gated by ena. The winner is the highest set index.
- IDLE:
  - If elig is nonzero: load intr_vec with the winner, set intr_req=1, go to REQ.
  - Latency: with an irq_src rise first sampled at edge E0, intr_req is high after edge E1.
- REQ:
  - intr_vec is frozen. A later higher-priority arrival does not preempt.
  - On intr_ack:
    - Clear pending[intr_vec] and set in_service[intr_vec].
    - irq_clr = one-hot(intr_vec) for exactly one cycle.
    - intr_req=0; go to SERVICE.
  - If ena=0 or irq_mask[intr_vec]=0 before ack: withdraw, meaning intr_req=0 next cycle, return to IDLE, pending retained.
- SERVICE:
  - intr_req stays 0.
  - On eoi: clear in_service, go to IDLE. Re-arbitration happens in IDLE on the next cycle.
- Ignored inputs:
  - intr_ack in IDLE or SERVICE.
  - eoi in IDLE or REQ.
  - If intr_ack and eoi arrive together in REQ, the ack is processed and the eoi is dropped.
- Simultaneous new edge and ack-clear on the same bit: set wins, so the bit stays pending.
- Simultaneous new edges on several sources: all are latched, and they are served in priority order on successive handshakes.
- Reset mid-operation: asynchronous return to reset values. Any in-flight handshake is abandoned and no irq_clr pulse is issued.

Decomposition:
- Shared package intr_pkg holds:
  - N_SRC, VEC_W
  - state enum {IDLE, REQ, SERVICE}
  - function onehot_dec(vec)
- One natural sub-module for winner selection: priority_sel. It is a combinational highest-index-wins encoder over elig and outputs any/vec.

Test Plan:
1. Reset, ena=1, mask=FF; pulse irq_src[5] → intr_req=1, intr_vec=5 one cycle after the sampled edge. Ack → irq_clr=0x20 for one cycle, in_service=0x20. Eoi → in_service=0, busy=0.
2. Sources 2 and 6 rise on the same cycle → vec=6 served first. After eoi → vec=2 requested. irq_clr sequence is 0x40 then 0x04.
3. In REQ with vec=3, raise source 7 → vec stays 3 until ack. After eoi for 3 → vec=7.
4. In REQ with vec=4, drop ena → intr_req falls next cycle, pending[4] stays set. Restore ena → request vec=4 again.
5. Source 1 edge on the same cycle as the ack of vec=1 → pending[1] remains 1. After eoi → second request with vec=1.
6. Assert rst_n=0 during SERVICE → all outputs 0 immediately. Stray ack or eoi after reset → no irq_clr, state stays IDLE.

Source files
------------

// File: rtl/intr_pkg.sv
// Shared types, sizes and helpers for the interrupt acknowledge controller.
package intr_pkg;

  localparam int N_SRC = 8;
  localparam int VEC_W = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_e;

  // Turn a source index back into a one-hot source mask.
  function automatic logic [N_SRC-1:0] onehot_dec(input logic [VEC_W-1:0] vec);
    onehot_dec      = '0;
    onehot_dec[vec] = 1'b1;
  endfunction

endpackage

// File: rtl/priority_sel.sv
// Highest-index-wins encoder over the eligible source set.
module priority_sel
  import intr_pkg::*;
(
  input  logic [N_SRC-1:0] elig_i,
  output logic             any_o,
  output logic [VEC_W-1:0] vec_o
);

  // Scan upward so the last (highest) set bit overrides lower ones.
  always_comb begin
    vec_o = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (elig_i[i]) vec_o = VEC_W'(i);
    end
    any_o = |elig_i;
  end

endmodule

// File: rtl/intr_ack_ctrl.sv
// Single-level interrupt controller: latches source events, presents the
// highest-priority pending source to the core over a req/ack handshake and
// tracks the in-service source until end-of-interrupt.
module intr_ack_ctrl
  import intr_pkg::*;
#(
  parameter int EDGE_MODE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_SRC-1:0] irq_src,
  input  logic [N_SRC-1:0] irq_mask,
  input  logic             ena,
  output logic             intr_req,
  output logic [VEC_W-1:0] intr_vec,
  input  logic             intr_ack,
  input  logic             eoi,
  output logic [N_SRC-1:0] irq_clr,
  output logic [N_SRC-1:0] in_service,
  output logic             busy
);

  state_e             state_q, state_d;
  logic [N_SRC-1:0]   src_q;
  logic [N_SRC-1:0]   pending_q, pending_d;
  logic [N_SRC-1:0]   inService_q, inService_d;
  logic [N_SRC-1:0]   irqClr_q, irqClr_d;
  logic               req_q, req_d;
  logic [VEC_W-1:0]   vec_q, vec_d;

  logic [N_SRC-1:0]   pending;
  logic [N_SRC-1:0]   elig;
  logic [N_SRC-1:0]   ackClr;
  logic               winAny;
  logic [VEC_W-1:0]   winVec;

  // Level mode bypasses the latch entirely; edge mode uses the sticky bits.
  assign pending = (EDGE_MODE != 0) ? pending_q : irq_src;

  // The source already in service cannot be re-requested until its eoi.
  assign elig = ena ? (pending & irq_mask & ~inService_q) : '0;

  priority_sel u_priority_sel (
    .elig_i (elig),
    .any_o  (winAny),
    .vec_o  (winVec)
  );

  // Handshake FSM plus pending bookkeeping; a new edge beats an ack clear.
  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    vec_d       = vec_q;
    inService_d = inService_q;
    irqClr_d    = '0;
    ackClr      = '0;
    case (state_q)
      IDLE: begin
        if (winAny) begin
          vec_d   = winVec;
          req_d   = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (intr_ack) begin
          ackClr      = onehot_dec(vec_q);
          inService_d = ackClr;
          irqClr_d    = ackClr;
          req_d       = 1'b0;
          state_d     = SERVICE;
        end else if (!ena || !irq_mask[vec_q]) begin
          req_d   = 1'b0;
          state_d = IDLE;
        end
      end
      SERVICE: begin
        if (eoi) begin
          inService_d = '0;
          state_d     = IDLE;
        end
      end
      default: begin
        req_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
    pending_d = (pending_q & ~ackClr) | (irq_src & ~src_q);
  end

  // State and output registers, all cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      src_q       <= '0;
      pending_q   <= '0;
      inService_q <= '0;
      irqClr_q    <= '0;
      req_q       <= 1'b0;
      vec_q       <= '0;
    end else begin
      state_q     <= state_d;
      src_q       <= irq_src;
      pending_q   <= pending_d;
      inService_q <= inService_d;
      irqClr_q    <= irqClr_d;
      req_q       <= req_d;
      vec_q       <= vec_d;
    end
  end

  assign intr_req   = req_q;
  assign intr_vec   = vec_q;
  assign irq_clr    = irqClr_q;
  assign in_service = inService_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_intr_ack_ctrl.sv
// Directed testbench for the interrupt acknowledge controller.
module tb_intr_ack_ctrl;

  logic       clk;
  logic       rst_n;
  logic [7:0] irq_src;
  logic [7:0] irq_mask;
  logic       ena;
  logic       intr_req;
  logic [2:0] intr_vec;
  logic       intr_ack;
  logic       eoi;
  logic [7:0] irq_clr;
  logic [7:0] in_service;
  logic       busy;

  int nChecks = 0;
  int nErrors = 0;

  intr_ack_ctrl #(.EDGE_MODE(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .irq_src    (irq_src),
    .irq_mask   (irq_mask),
    .ena        (ena),
    .intr_req   (intr_req),
    .intr_vec   (intr_vec),
    .intr_ack   (intr_ack),
    .eoi        (eoi),
    .irq_clr    (irq_clr),
    .in_service (in_service),
    .busy       (busy)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance n rising edges and settle just past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; irq_src = '0; irq_mask = '0; ena = 1'b0; intr_ack = 1'b0; eoi = 1'b0;
    #12;
    nChecks++; if (intr_req !== 1'b0) begin nErrors++; $display("[TB] FAIL reset_req: got %b expected 0", intr_req); end
    nChecks++; if (intr_vec !== 3'd0) begin nErrors++; $display("[TB] FAIL reset_vec: got %0d expected 0", intr_vec); end
    nChecks++; if (irq_clr !== 8'h00) begin nErrors++; $display("[TB] FAIL reset_clr: got %h expected 00", irq_clr); end
    nChecks++; if (in_service !== 8'h00) begin nErrors++; $display("[TB] FAIL reset_insvc: got %h expected 00", in_service); end
    nChecks++; if (busy !== 1'b0) begin nErrors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    step(1);
    rst_n = 1'b1; ena = 1'b1; irq_mask = 8'hFF;
    step(1);
  endtask

  task automatic test_single;
    irq_src = 8'h20;
    step(1);
    nChecks++; if (intr_req !== 1'b0) begin nErrors++; $display("[TB] FAIL single_latency: got %b expected 0", intr_req); end
    irq_src = 8'h00;
    step(1);
    nChecks++; if (intr_req !== 1'b1) begin nErrors++; $display("[TB] FAIL single_req: got %b expected 1", intr_req); end
    nChecks++; if (intr_vec !== 3'd5) begin nErrors++; $display("[TB] FAIL single_vec: got %0d expected 5", intr_vec); end
    nChecks++; if (busy !== 1'b1) begin nErrors++; $display("[TB] FAIL single_busy: got %b expected 1", busy); end
    intr_ack = 1'b1; step(1); intr_ack = 1'b0;
    nChecks++; if (irq_clr !== 8'h20) begin nErrors++; $display("[TB] FAIL single_clr: got %h expected 20", irq_clr); end
    nChecks++; if (in_service !== 8'h20) begin nErrors++; $display("[TB] FAIL single_insvc: got %h expected 20", in_service); end
    nChecks++; if (intr_req !== 1'b0) begin nErrors++; $display("[TB] FAIL single_req_drop: got %b expected 0", intr_req); end
    step(1);
    nChecks++; if (irq_clr !== 8'h00) begin nErrors++; $display("[TB] FAIL single_clr_once: got %h expected 00", irq_clr); end
    nChecks++; if (busy !== 1'b1) begin nErrors++; $display("[TB] FAIL single_svc_busy: got %b expected 1", busy); end
    eoi = 1'b1; step(1); eoi = 1'b0;
    nChecks++; if (in_service !== 8'h00) begin nErrors++; $display("[TB] FAIL single_eoi_insvc: got %h expected 00", in_service); end
    nChecks++; if (busy !== 1'b0) begin nErrors++; $display("[TB] FAIL single_eoi_busy: got %b expected 0", busy); end
  endtask

  task automatic test_priority;
    irq_src = 8'h44; step(1); irq_src = 8'h00; step(1);
    nChecks++; if (intr_vec !== 3'd6 || intr_req !== 1'b1) begin nErrors++; $display("[TB] FAIL prio_first: got req=%b vec=%0d expected req=1 vec=6", intr_req, intr_vec); end
    intr_ack = 1'b1; step(1); intr_ack = 1'b0;
    nChecks++; if (irq_clr !== 8'h40) begin nErrors++; $display("[TB] FAIL prio_clr_first: got %h expected 40", irq_clr); end
    step(1);
    nChecks++; if (intr_req !== 1'b0) begin nErrors++; $display("[TB] FAIL prio_no_nest: got %b expected 0", intr_req); end
    eoi = 1'b1; step(1); eoi = 1'b0;
    step(1);
    nChecks++; if (intr_vec !== 3'd2 || intr_req !== 1'b1) begin nErrors++; $display("[TB] FAIL prio_second: got req=%b vec=%0d expected req=1 vec=2", intr_req, intr_vec); end
    intr_ack = 1'b1; step(1); intr_ack = 1'b0;
    nChecks++; if (irq_clr !== 8'h04) begin nErrors++; $display("[TB] FAIL prio_clr_second: got %h expected 04", irq_clr); end
    eoi = 1'b1; step(1); eoi = 1'b0;
    step(1);
  endtask

  task automatic test_no_preempt;
    irq_src = 8'h08; step(1); irq_src = 8'h00; step(1);
    nChecks++; if (intr_vec !== 3'd3 || intr_req !== 1'b1) begin nErrors++; $display("[TB] FAIL preempt_req: got req=%b vec=%0d expected req=1 vec=3", intr_req, intr_vec); end
    irq_src = 8'h80; step(1); irq_src = 8'h00; step(1);
    nChecks++; if (intr_vec !== 3'd3) begin nErrors++; $display("[TB] FAIL preempt_frozen: got %0d expected 3", intr_vec); end
    intr_ack = 1'b1; step(1); intr_ack = 1'b0;
    nChecks++; if (irq_clr !== 8'h08) begin nErrors++; $display("[TB] FAIL preempt_clr: got %h expected 08", irq_clr); end
    eoi = 1'b1; step(1); eoi = 1'b0;
    nChecks++; if (intr_req !== 1'b0) begin nErrors++; $display("[TB] FAIL preempt_idle: got %b expected 0", intr_req); end
    step(1);
    nChecks++; if (intr_vec !== 3'd7 || intr_req !== 1'b1) begin nErrors++; $display("[TB] FAIL preempt_next: got req=%b vec=%0d expected req=1 vec=7", intr_req, intr_vec); end
    intr_ack = 1'b1; step(1); intr_ack = 1'b0;
    eoi = 1'b1; step(1); eoi = 1'b0;
    step(1);
  endtask

  task automatic test_withdraw;
    irq_src = 8'h10; step(1); irq_src = 8'h00; step(1);
    nChecks++; if (intr_vec !== 3'd4 || intr_req !== 1'b1) begin nErrors++; $display("[TB] FAIL withdraw_req: got req=%b vec=%0d expected req=1 vec=4", intr_req, intr_vec); end
    ena = 1'b0; step(1);
    nChecks++; if (intr_req !== 1'b0) begin nErrors++; $display("[TB] FAIL withdraw_drop: got %b expected 0", intr_req); end
    nChecks++; if (busy !== 1'b0) begin nErrors++; $display("[TB] FAIL withdraw_busy: got %b expected 0", busy); end
    step(1);
    nChecks++; if (intr_req !== 1'b0) begin nErrors++; $display("[TB] FAIL withdraw_hold: got %b expected 0", intr_req); end
    ena = 1'b1; step(1);
    nChecks++; if (intr_vec !== 3'd4 || intr_req !== 1'b1) begin nErrors++; $display("[TB] FAIL withdraw_rereq: got req=%b vec=%0d expected req=1 vec=4", intr_req, intr_vec); end
    intr_ack = 1'b1; step(1); intr_ack = 1'b0;
    nChecks++; if (irq_clr !== 8'h10) begin nErrors++; $display("[TB] FAIL withdraw_clr: got %h expected 10", irq_clr); end
    eoi = 1'b1; step(1); eoi = 1'b0;
    step(1);
  endtask

  task automatic test_set_wins;
    irq_src = 8'h02; step(1); irq_src = 8'h00; step(1);
    nChecks++; if (intr_vec !== 3'd1 || intr_req !== 1'b1) begin nErrors++; $display("[TB] FAIL setwin_req: got req=%b vec=%0d expected req=1 vec=1", intr_req, intr_vec); end
    irq_src = 8'h02; intr_ack = 1'b1; step(1); intr_ack = 1'b0; irq_src = 8'h00;
    nChecks++; if (irq_clr !== 8'h02) begin nErrors++; $display("[TB] FAIL setwin_clr: got %h expected 02", irq_clr); end
    nChecks++; if (in_service !== 8'h02) begin nErrors++; $display("[TB] FAIL setwin_insvc: got %h expected 02", in_service); end
    step(1);
    eoi = 1'b1; step(1); eoi = 1'b0;
    nChecks++; if (intr_req !== 1'b0) begin nErrors++; $display("[TB] FAIL setwin_idle: got %b expected 0", intr_req); end
    step(1);
    nChecks++; if (intr_vec !== 3'd1 || intr_req !== 1'b1) begin nErrors++; $display("[TB] FAIL setwin_rereq: got req=%b vec=%0d expected req=1 vec=1", intr_req, intr_vec); end
    intr_ack = 1'b1; step(1); intr_ack = 1'b0;
    eoi = 1'b1; step(1); eoi = 1'b0;
    step(1);
  endtask

  task automatic test_reset_midway;
    irq_src = 8'h01; step(1); irq_src = 8'h00; step(1);
    intr_ack = 1'b1; step(1); intr_ack = 1'b0;
    nChecks++; if (in_service !== 8'h01) begin nErrors++; $display("[TB] FAIL midrst_insvc: got %h expected 01", in_service); end
    step(1);
    #2 rst_n = 1'b0;
    #1;
    nChecks++; if (in_service !== 8'h00) begin nErrors++; $display("[TB] FAIL midrst_insvc0: got %h expected 00", in_service); end
    nChecks++; if (busy !== 1'b0) begin nErrors++; $display("[TB] FAIL midrst_busy: got %b expected 0", busy); end
    nChecks++; if (intr_req !== 1'b0 || intr_vec !== 3'd0 || irq_clr !== 8'h00) begin nErrors++; $display("[TB] FAIL midrst_outs: got req=%b vec=%0d clr=%h expected 0/0/00", intr_req, intr_vec, irq_clr); end
    step(1);
    rst_n = 1'b1;
    intr_ack = 1'b1; step(1); intr_ack = 1'b0;
    nChecks++; if (irq_clr !== 8'h00 || busy !== 1'b0) begin nErrors++; $display("[TB] FAIL stray_ack: got clr=%h busy=%b expected 00/0", irq_clr, busy); end
    eoi = 1'b1; step(1); eoi = 1'b0;
    nChecks++; if (irq_clr !== 8'h00 || busy !== 1'b0 || intr_req !== 1'b0) begin nErrors++; $display("[TB] FAIL stray_eoi: got clr=%h busy=%b req=%b expected 00/0/0", irq_clr, busy, intr_req); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_no_preempt();
    test_withdraw();
    test_set_wins();
    test_reset_midway();
    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
